// File: rtl/skew_feeder_pkg.sv
// Shared constants, FSM encoding and size clamping for the skew feeder.
// The block sits between the data buffer and a systolic array.
package skew_pkg;

    localparam int N      = 16;
    localparam int DW     = 8;
    localparam int SIZE_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // A request of 0 lanes still feeds one lane; requests above the array size saturate.
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] req,
                                                     input logic [SIZE_W-1:0] max_size);
        if (req == '0) return SIZE_W'(1);
        if (req > max_size) return max_size;
        return req;
    endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// Bus between the data buffer side (master) and the skew feeder (slave).
// in_valid qualifies gemm_size/row_in/col_in; the feeder has no ready and takes every valid cycle; row_vld/col_vld qualify each output lane.
interface skew_feeder_if #(
    parameter int N  = skew_pkg::N,
    parameter int DW = skew_pkg::DW
);
    import skew_pkg::*;

    logic [SIZE_W-1:0] gemm_size;
    logic              in_valid;
    logic [N*DW-1:0]   row_in;
    logic [N*DW-1:0]   col_in;
    logic [N*DW-1:0]   row_out;
    logic [N*DW-1:0]   col_out;
    logic [N-1:0]      row_vld;
    logic [N-1:0]      col_vld;
    logic              busy;
    logic              feed_done;
    state_t            state;

    modport master (
        output gemm_size, in_valid, row_in, col_in,
        input  row_out, col_out, row_vld, col_vld, busy, feed_done, state
    );

    modport slave (
        input  gemm_size, in_valid, row_in, col_in,
        output row_out, col_out, row_vld, col_vld, busy, feed_done, state
    );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain carrying one lane's data and valid.
// Output is the last stage, so a value entering at cycle t leaves at cycle t+DEPTH.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_data,
    input  logic          d_valid,
    output logic [DW-1:0] q_data,
    output logic          q_valid
);

    logic [DW-1:0]    data_pipe [DEPTH];
    logic [DEPTH-1:0] vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) data_pipe[i] <= '0;
            vld_pipe <= '0;
        end else begin
            data_pipe[0] <= d_data;
            vld_pipe[0]  <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_pipe[i] <= data_pipe[i-1];
                vld_pipe[i]  <= vld_pipe[i-1];
            end
        end
    end

    assign q_data  = data_pipe[DEPTH-1];
    assign q_valid = vld_pipe[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Skews data_buffer vectors into a systolic array: lane k is delayed k+1 cycles,
// lanes beyond the latched size stay quiet, and a stream end is flagged on feed_done.
module skew_feeder #(
    parameter int N  = skew_pkg::N,
    parameter int DW = skew_pkg::DW
) (
    input  logic         clk,
    input  logic         rst,
    skew_feeder_if.slave bus
);
    import skew_pkg::*;

    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(N);

    state_t            state;
    logic [SIZE_W-1:0] size_lat;
    logic [SIZE_W-1:0] drain_cnt;
    logic [SIZE_W-1:0] eff_size;
    logic              busy_q;
    logic [N*DW-1:0]   row_q;
    logic [N*DW-1:0]   col_q;
    logic [N-1:0]      row_v;
    logic [N-1:0]      col_v;

    // The sample that opens a stream is gated with the size being latched on that same edge.
    always_comb begin
        eff_size = size_lat;
        if (state == IDLE) eff_size = clamp_size(bus.gemm_size, MAX_SIZE);
    end

    // The STREAM cycle with no input already counts as the first drain cycle, so
    // drain_cnt reaches 0 exactly when lane size_lat-1 shows the last sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            size_lat  <= SIZE_W'(1);
            drain_cnt <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state    <= STREAM;
                        size_lat <= eff_size;
                        busy_q   <= 1'b1;
                    end
                end
                STREAM: begin
                    if (!bus.in_valid) begin
                        if (size_lat == SIZE_W'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= size_lat - SIZE_W'(2);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.in_valid) begin
                        state <= STREAM;
                    end else if (drain_cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - SIZE_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam logic [SIZE_W-1:0] LANE = SIZE_W'(k);

        logic          lane_on;
        logic [DW-1:0] row_d;
        logic [DW-1:0] col_d;

        // Zero data on bubbles and on inactive lanes keeps idle array inputs at 0.
        assign lane_on = bus.in_valid && (LANE < eff_size);
        assign row_d   = lane_on ? bus.row_in[k*DW +: DW] : '0;
        assign col_d   = lane_on ? bus.col_in[k*DW +: DW] : '0;

        skew_delay_line #(.DEPTH(k + 1), .DW(DW)) u_row (
            .clk     (clk),
            .rst     (rst),
            .d_data  (row_d),
            .d_valid (lane_on),
            .q_data  (row_q[k*DW +: DW]),
            .q_valid (row_v[k])
        );

        skew_delay_line #(.DEPTH(k + 1), .DW(DW)) u_col (
            .clk     (clk),
            .rst     (rst),
            .d_data  (col_d),
            .d_valid (lane_on),
            .q_data  (col_q[k*DW +: DW]),
            .q_valid (col_v[k])
        );
    end

    assign bus.row_out   = row_q;
    assign bus.col_out   = col_q;
    assign bus.row_vld   = row_v;
    assign bus.col_vld   = col_v;
    assign bus.busy      = busy_q;
    assign bus.state     = state;
    assign bus.feed_done = !bus.in_valid &&
                           (((state == STREAM) && (size_lat == SIZE_W'(1))) ||
                            ((state == DRAIN) && (drain_cnt == '0)));

endmodule
